jk_excite_counter: RTL

- Modulo-N synchronous up/down counter that drives an external bank of WIDTH JK flip-flops. The bank holds the counter state; this block generates the per-bit J/K excitation.
- Sits directly upstream of the JK flip-flop bank. Computes the next state from a registered shadow copy of the bank.
- Checks the bank's Q feedback against the shadow every cycle and flags divergence.

---
 rtl/jk_excite_counter.sv | 89 ++++++++
 1 files changed

// File: rtl/jk_excite_counter.sv
// Modulo-N up/down counter that excites an external JK flip-flop bank from a shadow copy
// of its state, and flags any divergence between the bank feedback and that shadow.
module jk_excite_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] fb_q,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("jk_excite_counter: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] nxt;
    logic             wrap_step;

    // Load clamps out-of-range values to zero without flagging an error.
    always_comb begin
        nxt       = q_q;
        wrap_step = 1'b0;
        if (load) begin
            if ({1'b0, load_val} < MOD_EXT) begin
                nxt = load_val;
            end else begin
                nxt = '0;
            end
        end else if (en) begin
            if (up_dn) begin
                wrap_step = (q_q == MAX_Q);
                nxt       = wrap_step ? '0 : q_q + 1'b1;
            end else begin
                wrap_step = (q_q == '0);
                nxt       = wrap_step ? MAX_Q : q_q - 1'b1;
            end
        end
    end

    always_comb begin
        q_d    = nxt;
        wrap_d = wrap_step;
        err_d  = err_q | (fb_q != q_q);
        tc     = rst_n & wrap_step;
        // Reset drives K high on every bit so the bank clears on the same edge as the shadow.
        if (rst_n) begin
            J = ~q_q & nxt;
            K = q_q & ~nxt;
        end else begin
            J = '0;
            K = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule
